// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, FSM state type and the S-box function
package aes_pkg;
  localparam int NB_BYTES = 16;
  localparam int WORD_BYTES = 4;
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // inverse as x^254 (0 maps to 0), followed by the affine transform
  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] s, r;
    s = gf_mul(x, x);
    r = s;
    for (int i = 0; i < 6; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
endpackage

// File: rtl/sbox_lane_array.sv
// sbox_lane_array: LANES combinational S-box lanes, byte 0 in the leading bits
module sbox_lane_array
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic [0:LANES*8-1] din,
  output logic [0:LANES*8-1] dout
);
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign dout[8*g +: 8] = aes_sbox(din[8*g +: 8]);
  end
endmodule

// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: folded AES SubBytes/SubWord over LANES S-boxes with valid/ready handshakes
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int LANES = 4,
  parameter int PIPE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  input  logic         in_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data
);
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end
  localparam int W = 8 * LANES;
  localparam int BEATS_WORD = LANES >= WORD_BYTES ? 1 : WORD_BYTES / LANES;
  localparam logic [3:0] STEP = 4'(LANES);
  localparam logic [3:0] FULL_LAST = 4'(NB_BYTES - LANES);
  localparam logic [3:0] WORD_LAST = 4'((BEATS_WORD - 1) * LANES);
  state_t state;
  logic [3:0] idx, pipe_idx, wr_idx;
  logic word_q, pipe_vld, wr_en, last;
  logic [0:127] work, work_d, wr_ext;
  logic [0:W-1] lane_in, lane_out, pipe_data, wr_data;
  assign lane_in = work[{idx, 3'b000} +: W];
  sbox_lane_array #(.LANES(LANES)) u_lanes (.din(lane_in), .dout(lane_out));
  assign last = idx == (word_q ? WORD_LAST : FULL_LAST);
  // with PIPE the commit into the working register lags the S-box by one cycle
  assign wr_en = PIPE != 0 ? pipe_vld : state == BUSY;
  assign wr_idx = PIPE != 0 ? pipe_idx : idx;
  assign wr_data = PIPE != 0 ? pipe_data : lane_out;
  assign wr_ext = 128'(wr_data) << (128 - W);
  for (genvar k = 0; k < NB_BYTES; k++) begin : g_byte
    logic [3:0] rel;
    logic hit;
    assign rel = 4'(k) - wr_idx;
    assign hit = wr_en && ({1'b0, rel} < 5'(LANES)) && (!word_q || k < WORD_BYTES);
    assign work_d[8*k +: 8] = hit ? wr_ext[{rel, 3'b000} +: 8] : work[8*k +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      word_q <= 1'b0;
      work <= '0;
      pipe_vld <= 1'b0;
      pipe_idx <= '0;
      pipe_data <= '0;
    end else begin
      pipe_vld <= state == BUSY;
      pipe_idx <= idx;
      pipe_data <= lane_out;
      work <= work_d;
      case (state)
        IDLE: if (in_valid) begin
          work <= in_data;
          word_q <= in_word;
          idx <= '0;
          state <= BUSY;
        end
        BUSY: begin
          idx <= last ? 4'd0 : idx + STEP;
          state <= !last ? BUSY : PIPE != 0 ? DRAIN : DONE;
        end
        DRAIN: state <= DONE;
        DONE: state <= out_ready ? IDLE : DONE;
        default: state <= IDLE;
      endcase
    end
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign out_data = work;
endmodule

// File: tb/tb_sub_bytes_engine.sv
// tb_sub_bytes_engine: scoreboard bench over several LANES/PIPE configurations
module tb_sub_bytes_engine;
  localparam int N = 5;
  localparam int LN[N] = '{4, 1, 2, 8, 16};
  localparam int PP[N] = '{0, 1, 1, 0, 1};
  typedef struct {
    int d;
    logic [127:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid[N], in_ready[N], in_word[N], out_valid[N], out_ready[N];
  logic [0:127] in_data[N], out_data[N];
  logic [7:0] sbt[256];
  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    sub_bytes_engine #(.LANES(LN[g]), .PIPE(PP[g])) u_dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid[g]),
      .in_ready(in_ready[g]),
      .in_data(in_data[g]),
      .in_word(in_word[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data(out_data[g])
    );
  end
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // table built from the multiplicative generator walk, independent of GF inversion
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    repeat (255) begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      q = q[7] ? q ^ 8'h09 : q;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbt[p] = x ^ 8'h63;
    end
    sbt[0] = 8'h63;
  endtask
  function automatic logic [127:0] model(input logic [127:0] x, input bit word);
    logic [127:0] r;
    r = x;
    for (int k = 0; k < 16; k++)
      if (!word || k < 4) r[127-8*k -: 8] = sbt[x[127-8*k -: 8]];
    return r;
  endfunction
  task automatic run_block(input int d, input logic [127:0] data, input bit word,
                           input logic [127:0] exp, input int stall);
    int t, lat, want;
    exp_t e;
    sb_q.push_back('{d, exp});
    want = (word ? (LN[d] >= 4 ? 1 : 4 / LN[d]) : 16 / LN[d]) + PP[d];
    in_data[d] = data;
    in_word[d] = word;
    in_valid[d] = 1'b1;
    t = 0;
    while (!in_ready[d] && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check($sformatf("accept_ready_d%0d", d), in_ready[d], 1);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    out_ready[d] = stall == 0;
    lat = 0;
    while (!out_valid[d] && lat < 100) begin
      in_data[d] = {$urandom, $urandom, $urandom, $urandom};
      in_word[d] = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency_d%0d", d), lat, want);
    check($sformatf("done_in_ready_d%0d", d), in_ready[d], 0);
    e = sb_q.pop_front();
    check($sformatf("data_d%0d", e.d), out_data[d], e.data);
    if (stall > 0) begin
      in_valid[d] = 1'b1;
      repeat (stall) begin
        @(posedge clk); #1;
      end
      check($sformatf("stall_valid_d%0d", d), out_valid[d], 1);
      check($sformatf("stall_in_ready_d%0d", d), in_ready[d], 0);
      check($sformatf("stall_data_d%0d", d), out_data[d], e.data);
      in_valid[d] = 1'b0;
    end
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    check($sformatf("post_valid_d%0d", d), out_valid[d], 0);
    check($sformatf("post_in_ready_d%0d", d), in_ready[d], 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
  initial begin
    logic [127:0] v;
    bit w;
    build_sbox();
    for (int d = 0; d < N; d++) begin
      in_valid[d] = 1'b0;
      in_word[d] = 1'b0;
      out_ready[d] = 1'b0;
      in_data[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) begin
      check($sformatf("rst_in_ready_d%0d", d), in_ready[d], 1);
      check($sformatf("rst_out_valid_d%0d", d), out_valid[d], 0);
      check($sformatf("rst_out_data_d%0d", d), out_data[d], 0);
    end
    rst = 1'b0;
    for (int d = 0; d < N; d++) begin
      run_block(d, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0,
                128'hd42711aee0bf98f1b8b45de51e415230, 0);
      run_block(d, 128'hcf4f3c09a5a5a5a5a5a5a5a5a5a5a5a5, 1'b1,
                128'h8a84eb01a5a5a5a5a5a5a5a5a5a5a5a5, 0);
      run_block(d, 128'h0, 1'b0, {16{8'h63}}, 0);
    end
    run_block(0, 128'h00112233445566778899aabbccddeeff, 1'b0,
              128'h638293c31bfc33f5c4eeacea4bc12816, 10);
    run_block(1, 128'h00112233445566778899aabbccddeeff, 1'b0,
              128'h638293c31bfc33f5c4eeacea4bc12816, 10);
    in_data[1] = 128'h0123456789abcdef0123456789abcdef;
    in_word[1] = 1'b0;
    in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", out_valid[1], 0);
    check("midrst_in_ready", in_ready[1], 1);
    check("midrst_out_data", out_data[1], 0);
    v = 128'hfedcba9876543210fedcba9876543210;
    run_block(1, v, 1'b0, model(v, 1'b0), 0);
    for (int d = 0; d < N; d++)
      repeat (4) begin
        v = {$urandom, $urandom, $urandom, $urandom};
        w = 1'($urandom);
        run_block(d, v, w, model(v, w), $urandom_range(0, 3));
      end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
